// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state type, board defaults and the
// oversample divider calculation used by both RX and TX.
package uart_pkg;

    localparam int UART_CLK_HZ = 100000000;
    localparam int UART_BAUD   = 115200;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_HIGH = 3'd4
    } rx_state_t;

    // Clocks per oversample tick, rounded to nearest.
    function automatic int calc_div(input int clk_hz, input int baud, input int ovs);
        return (clk_hz + (baud * ovs) / 2) / (baud * ovs);
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Byte-side handshake of the UART receiver: valid/ready data plus
// status pulses. master = receiver, slave = consumer.
interface uart_rx_if;

    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    modport master (
        output rx_data,
        output rx_valid,
        output frame_err,
        output overrun,
        output busy,
        input  rx_ready
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        input  frame_err,
        input  overrun,
        input  busy,
        output rx_ready
    );

endinterface

// File: rtl/uart_baud_tick.sv
// Free-running oversample tick: one-cycle pulse every DIV clocks, used as a
// clock enable by the UART datapaths.
module uart_baud_tick #(
    parameter int DIV = 54
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == CNT_LAST);

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with 16x (or 8x) oversampling, mid-bit sampling,
// start-glitch rejection, framing-error and overrun pulses.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_HZ = UART_CLK_HZ,
    parameter int BAUD   = UART_BAUD,
    parameter int OVS    = 16,
    parameter int DIV    = calc_div(CLK_HZ, BAUD, OVS)
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      rxd_in,
    uart_rx_if.master rx_if
);

    localparam int SUB_W = $clog2(OVS);
    localparam logic [SUB_W-1:0] SUB_MID  = SUB_W'(OVS / 2 - 1);
    localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(OVS - 1);

    localparam logic [2:0] ST_IDLE      = IDLE;
    localparam logic [2:0] ST_START     = START;
    localparam logic [2:0] ST_DATA      = DATA;
    localparam logic [2:0] ST_STOP      = STOP;
    localparam logic [2:0] ST_WAIT_HIGH = WAIT_HIGH;

    logic             tick;
    logic             rxs;
    logic [1:0]       sync_q,  sync_d;
    logic [2:0]       state_q, state_d;
    logic [SUB_W-1:0] sub_q,   sub_d;
    logic [2:0]       idx_q,   idx_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       data_q,  data_d;
    logic             valid_q, valid_d;
    logic             ferr_q,  ferr_d;
    logic             ovr_q,   ovr_d;
    logic             deliver;

    uart_baud_tick #(
        .DIV (DIV)
    ) u_baud_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    assign rxs    = sync_q[1];
    assign sync_d = {sync_q[0], rxd_in};

    always_comb begin
        state_d = state_q;
        sub_d   = sub_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = valid_q;
        ferr_d  = 1'b0;
        ovr_d   = 1'b0;
        deliver = 1'b0;

        if (valid_q && rx_if.rx_ready) begin
            valid_d = 1'b0;
        end

        if (tick) begin
            case (state_q)
                ST_IDLE: begin
                    if (!rxs) begin
                        state_d = ST_START;
                        sub_d   = '0;
                    end
                end
                ST_START: begin
                    sub_d = sub_q + 1'b1;
                    if (sub_q == SUB_MID) begin
                        sub_d = '0;
                        idx_d = '0;
                        state_d = rxs ? ST_IDLE : ST_DATA;
                    end
                end
                ST_DATA: begin
                    // Sub-bit counter wraps naturally; each wrap lands mid-bit.
                    sub_d = sub_q + 1'b1;
                    if (sub_q == SUB_LAST) begin
                        shift_d[idx_q] = rxs;
                        idx_d = idx_q + 3'd1;
                        if (idx_q == 3'd7) begin
                            state_d = ST_STOP;
                        end
                    end
                end
                ST_STOP: begin
                    sub_d = sub_q + 1'b1;
                    if (sub_q == SUB_LAST) begin
                        if (rxs) begin
                            deliver = 1'b1;
                            state_d = ST_IDLE;
                        end else begin
                            ferr_d  = 1'b1;
                            state_d = ST_WAIT_HIGH;
                        end
                    end
                end
                ST_WAIT_HIGH: begin
                    if (rxs) begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        // A byte consumed in this same cycle frees the slot for the new one.
        if (deliver) begin
            if (!valid_q || rx_if.rx_ready) begin
                data_d  = shift_q;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q  <= 2'b11;
            state_q <= ST_IDLE;
            sub_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            state_q <= state_d;
            sub_q   <= sub_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

    assign rx_if.rx_data   = data_q;
    assign rx_if.rx_valid  = valid_q;
    assign rx_if.frame_err = ferr_q;
    assign rx_if.overrun   = ovr_q;
    assign rx_if.busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed and randomized frames into uart_rx; delivered bytes and status
// pulses are compared against a queue of the bytes the line should yield.
module tb_uart_rx;
    import uart_pkg::*;

    // Scaled clock so one bit is exactly OVS*DIV clocks and the run stays short.
    localparam int CLK_HZ = 14745600;
    localparam int BAUD   = 115200;
    localparam int OVS    = 16;
    localparam int DIV    = calc_div(CLK_HZ, BAUD, OVS);
    localparam int BIT    = CLK_HZ / BAUD;
    // 9.5 bit times, +-1 tick, +2 synchroniser clocks
    localparam int LAT_NOM = (19 * BIT) / 2;
    localparam int LAT_MIN = LAT_NOM - DIV;
    localparam int LAT_MAX = LAT_NOM + DIV + 2;

    logic clk = 1'b0;
    logic rst;
    logic rxd_in;
    uart_rx_if rx_bus();

    uart_rx #(
        .CLK_HZ (CLK_HZ),
        .BAUD   (BAUD),
        .OVS    (OVS)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .rxd_in (rxd_in),
        .rx_if  (rx_bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: sampled on the falling edge, i.e. what the next rising edge sees.
    logic [7:0] got_q[$];
    int   ferr_cnt = 0;
    int   ovr_cnt = 0;
    int   valid_cycles = 0;
    int   rise_cyc = 0;
    logic valid_prev = 1'b0;

    always @(negedge clk) begin
        if (rx_bus.rx_valid && rx_bus.rx_ready) got_q.push_back(rx_bus.rx_data);
        if (rx_bus.frame_err) ferr_cnt++;
        if (rx_bus.overrun) ovr_cnt++;
        if (rx_bus.rx_valid) valid_cycles++;
        if (rx_bus.rx_valid && !valid_prev) rise_cyc = cyc;
        valid_prev = rx_bus.rx_valid;
    end

    logic [7:0] exp_q[$];
    int rd_idx = 0;
    int total = 0;
    int passed = 0;
    int failed = 0;
    int last_edge = 0;
    int fe_base, ov_base, vc_base;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) wait_clks(1);
    endtask

    task automatic mark();
        fe_base = ferr_cnt;
        ov_base = ovr_cnt;
        vc_base = valid_cycles;
    endtask

    // Drives the first nbits of {stop, data[7:0], start}, LSB first, then idles high.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int nbits);
        logic [9:0] f;
        f = {stop_bit, b, 1'b0};
        last_edge = cyc;
        for (int i = 0; i < nbits; i++) begin
            rxd_in = f[i];
            wait_clks(BIT);
        end
        rxd_in = 1'b1;
    endtask

    task automatic check_deliv(input string tag);
        logic [7:0] e;
        check({tag, "_count"}, got_q.size() - rd_idx, exp_q.size());
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (rd_idx < got_q.size()) begin
                $display("rx %s: byte %02h expected %02h", tag, got_q[rd_idx], e);
                check(tag, got_q[rd_idx], e);
                rd_idx++;
            end
        end
        rd_idx = got_q.size();
    endtask

    initial begin
        logic [7:0] hoge [4];
        logic [7:0] b;
        int lat;
        int gap;
        hoge = '{8'h48, 8'h4F, 8'h47, 8'h45};

        rst = 1'b1;
        rxd_in = 1'b1;
        rx_bus.rx_ready = 1'b1;
        wait_clks(3);
        check("rst_valid", rx_bus.rx_valid, 0);
        check("rst_data", rx_bus.rx_data, 0);
        check("rst_ferr", rx_bus.frame_err, 0);
        check("rst_ovr", rx_bus.overrun, 0);
        check("rst_busy", rx_bus.busy, 0);
        rst = 1'b0;
        wait_clks(5);

        // Single byte, latency and one-cycle valid
        mark();
        send_frame(8'h48, 1'b1, 10);
        exp_q.push_back(8'h48);
        wait_clks(2 * BIT);
        lat = rise_cyc - last_edge;
        $display("latency %0d clk (window %0d..%0d)", lat, LAT_MIN, LAT_MAX);
        check("latency", (lat >= LAT_MIN && lat <= LAT_MAX), 1);
        check("valid_pulse", valid_cycles - vc_base, 1);
        check("single_ferr", ferr_cnt - fe_base, 0);
        check("single_ovr", ovr_cnt - ov_base, 0);
        check_deliv("single");

        // Back-to-back HOGE
        mark();
        for (int i = 0; i < 4; i++) begin
            send_frame(hoge[i], 1'b1, 10);
            exp_q.push_back(hoge[i]);
        end
        wait_clks(2 * BIT);
        check_deliv("hoge");
        check("hoge_ferr", ferr_cnt - fe_base, 0);
        check("hoge_ovr", ovr_cnt - ov_base, 0);

        // Short low glitch
        mark();
        rxd_in = 1'b0;
        wait_clks(40);
        check("glitch_busy_hi", rx_bus.busy, 1);
        rxd_in = 1'b1;
        wait_clks(BIT);
        check("glitch_busy_lo", rx_bus.busy, 0);
        check("glitch_valid", valid_cycles - vc_base, 0);
        check("glitch_ferr", ferr_cnt - fe_base, 0);

        // Framing error, then a good frame
        mark();
        send_frame(8'h55, 1'b0, 10);
        wait_clks(BIT);
        check("ferr_pulse", ferr_cnt - fe_base, 1);
        check("ferr_valid", valid_cycles - vc_base, 0);
        check("ferr_busy", rx_bus.busy, 0);
        send_frame(8'hA5, 1'b1, 10);
        exp_q.push_back(8'hA5);
        wait_clks(2 * BIT);
        check_deliv("after_ferr");
        check("after_ferr_cnt", ferr_cnt - fe_base, 1);

        // Overrun with consumer stalled
        mark();
        rx_bus.rx_ready = 1'b0;
        send_frame(8'h11, 1'b1, 10);
        wait_clks(2 * BIT);
        check("ovr_hold_valid", rx_bus.rx_valid, 1);
        check("ovr_hold_data", rx_bus.rx_data, 8'h11);
        check("ovr_none_yet", ovr_cnt - ov_base, 0);
        send_frame(8'h22, 1'b1, 10);
        wait_clks(2 * BIT);
        check("ovr_pulse", ovr_cnt - ov_base, 1);
        check("ovr_data_kept", rx_bus.rx_data, 8'h11);
        rx_bus.rx_ready = 1'b1;
        wait_clks(1);
        rx_bus.rx_ready = 1'b0;
        check("ovr_valid_clr", rx_bus.rx_valid, 0);
        exp_q.push_back(8'h11);
        check_deliv("overrun");

        // Reset mid-byte with a pending byte
        mark();
        send_frame(8'h99, 1'b1, 10);
        wait_clks(2 * BIT);
        check("pend_valid", rx_bus.rx_valid, 1);
        send_frame(8'h3C, 1'b1, 5);
        check("mid_busy", rx_bus.busy, 1);
        rst = 1'b1;
        #1;
        check("arst_valid", rx_bus.rx_valid, 0);
        check("arst_data", rx_bus.rx_data, 0);
        check("arst_busy", rx_bus.busy, 0);
        check("arst_ferr", rx_bus.frame_err, 0);
        check("arst_ovr", rx_bus.overrun, 0);
        wait_clks(2);
        rst = 1'b0;
        mark();
        wait_clks(2 * BIT);
        check("arst_no_partial", valid_cycles - vc_base, 0);
        check("arst_no_ferr", ferr_cnt - fe_base, 0);
        rx_bus.rx_ready = 1'b1;
        send_frame(8'hC3, 1'b1, 10);
        exp_q.push_back(8'hC3);
        wait_clks(2 * BIT);
        check_deliv("post_rst");

        // Consume and load in the same cycle: ready pulses exactly at B's stop sample
        mark();
        rx_bus.rx_ready = 1'b0;
        send_frame(8'h5A, 1'b1, 10);
        begin
            int edge_a;
            edge_a = last_edge;
            wait_clks(BIT);
            lat = rise_cyc - edge_a;
            check("same_cyc_lat", (lat >= LAT_MIN && lat <= LAT_MAX), 1);
            wait_until(edge_a + 12 * BIT);
            fork
                send_frame(8'hE7, 1'b1, 10);
                begin
                    wait_until(edge_a + 12 * BIT + lat - 1);
                    rx_bus.rx_ready = 1'b1;
                    wait_clks(1);
                    rx_bus.rx_ready = 1'b0;
                end
            join
        end
        wait_clks(2 * BIT);
        check("same_cyc_ovr", ovr_cnt - ov_base, 0);
        check("same_cyc_valid", rx_bus.rx_valid, 1);
        check("same_cyc_data", rx_bus.rx_data, 8'hE7);
        rx_bus.rx_ready = 1'b1;
        wait_clks(1);
        exp_q.push_back(8'h5A);
        exp_q.push_back(8'hE7);
        check_deliv("same_cyc");

        // Random bytes with random idle gaps (including none)
        mark();
        for (int i = 0; i < 6; i++) begin
            b = 8'($urandom_range(0, 255));
            gap = $urandom_range(0, 3 * BIT);
            if (gap > 0) wait_clks(gap);
            send_frame(b, 1'b1, 10);
            exp_q.push_back(b);
        end
        wait_clks(2 * BIT);
        check_deliv("random");
        check("random_ferr", ferr_cnt - fe_base, 0);
        check("random_ovr", ovr_cnt - ov_base, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
